// File: rtl/cache_pkg.sv
// ============================================================================
// Module   : cache_pkg
// Purpose  : Shared widths, error fill word and FSM state encoding for the
//            cache refill engine.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int CTR_W  = 5;

    localparam logic [DATA_W-1:0] ERR_DATA_DFLT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RF   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage : cache_pkg

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================================
// Module   : mem_timeout_ctr
// Purpose  : Per-phase wait counter; flags the cycle whose non-ack would make
//            the count reach the timeout limit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_timeout_ctr
    import cache_pkg::*;
#(
    parameter int unsigned TERMINAL = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_term
);

    localparam logic [CTR_W-1:0] c_TERM = CTR_W'(TERMINAL);

    logic [CTR_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_term = (r_count == c_TERM);

endmodule : mem_timeout_ctr

`default_nettype wire

// File: rtl/cache_refill_engine.sv
// ============================================================================
// Module   : cache_refill_engine
// Purpose  : Services one cache miss at a time: optional victim writeback,
//            line refill read, then a one-cycle fill response.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_refill_engine
    import cache_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYC = 16,
    parameter logic [DATA_W-1:0] ERR_DATA    = ERR_DATA_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              miss_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [DATA_W-1:0] victim_data,
    output logic              fill_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_miss_addr;

    logic w_accept;
    logic w_in_phase;
    logic w_ctr_clr;
    logic w_ctr_en;
    logic w_ctr_term;

    assign miss_ready = (r_state == ST_IDLE);
    assign w_accept   = miss_valid && miss_ready;
    assign w_in_phase = (r_state == ST_WB) || (r_state == ST_RF);

    // An ack ends the phase, so the next phase starts counting from zero.
    assign w_ctr_clr  = !w_in_phase || mem_ack;
    assign w_ctr_en   = w_in_phase && !mem_ack;

    mem_timeout_ctr #(
        .TERMINAL (TIMEOUT_CYC - 1)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_ctr_clr),
        .i_enable (w_ctr_en),
        .o_term   (w_ctr_term)
    );

    // Victim address/data live directly in mem_addr/mem_wdata for the WB phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_miss_addr <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            fill_valid  <= 1'b0;
            fill_data   <= '0;
            fill_err    <= 1'b0;
        end else begin
            fill_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_miss_addr <= miss_addr;
                        mem_req     <= 1'b1;
                        if (miss_dirty) begin
                            r_state   <= ST_WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= victim_addr;
                            mem_wdata <= victim_data;
                        end else begin
                            r_state  <= ST_RF;
                            mem_we   <= 1'b0;
                            mem_addr <= miss_addr;
                        end
                    end
                end
                ST_WB, ST_RF: begin
                    if (mem_ack) begin
                        if (r_state == ST_WB) begin
                            r_state  <= ST_RF;
                            mem_we   <= 1'b0;
                            mem_addr <= r_miss_addr;
                        end else begin
                            r_state   <= ST_RESP;
                            mem_req   <= 1'b0;
                            fill_data <= mem_rdata;
                            fill_err  <= 1'b0;
                        end
                    end else if (w_ctr_term) begin
                        // Abort from either phase; a WB abort never reaches RF.
                        r_state   <= ST_RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        fill_data <= ERR_DATA;
                        fill_err  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    fill_valid <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : cache_refill_engine

`default_nettype wire
